// File: rtl/canvas_pixel_writer_if.sv
// Brush-stroke handshake and frame-buffer RAM write port of the canvas pixel writer.
// CANVAS_ERASER_EN adds the draw_erase signal to the stroke.
interface canvas_pixel_writer_if #(
  parameter int unsigned coord_width            = 7,
  parameter int unsigned input_pixel_addr_width = 14
);
  logic                              draw_valid;
  logic                              draw_ready;
  logic [coord_width-1:0]            draw_x;
  logic [coord_width-1:0]            draw_y;
`ifdef CANVAS_ERASER_EN
  logic                              draw_erase;
`endif
  logic [input_pixel_addr_width-1:0] pixel_addr;
  logic                              pixel_data;
  logic                              pixel_we;

  modport master (
    output draw_valid, draw_x, draw_y,
`ifdef CANVAS_ERASER_EN
    output draw_erase,
`endif
    input  draw_ready, pixel_addr, pixel_data, pixel_we
  );

  modport slave (
    input  draw_valid, draw_x, draw_y,
`ifdef CANVAS_ERASER_EN
    input  draw_erase,
`endif
    output draw_ready, pixel_addr, pixel_data, pixel_we
  );
endinterface

// File: rtl/canvas_pixel_writer.sv
// Paints square 1-bit brush strokes (or a full clear) into a single-port frame-buffer RAM.
// Optional CANVAS_ERASER_EN: strokes carry draw_erase and then write 0s instead of 1s.
module canvas_pixel_writer #(
  parameter int unsigned input_matrix_side_length = 112,
  parameter int unsigned brush_size               = 4,
  parameter int unsigned coord_width              = $clog2(input_matrix_side_length),
  parameter int unsigned input_pixel_addr_width   = $clog2(input_matrix_side_length**2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  canvas_pixel_writer_if.slave  bus,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned pos_width  = coord_width + 1;
  localparam int unsigned ext_width  = coord_width + 2;
  localparam int unsigned cnt_width  = (brush_size > 1) ? $clog2(brush_size) : 1;
  localparam int unsigned prod_width = input_pixel_addr_width + coord_width;

  localparam logic [input_pixel_addr_width-1:0] last_addr =
    input_pixel_addr_width'(input_matrix_side_length * input_matrix_side_length - 1);
  localparam logic [cnt_width-1:0]        brush_last = cnt_width'(brush_size - 1);
  localparam logic signed [ext_width-1:0] side_ext   = ext_width'(input_matrix_side_length);

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_CLEAR,
    S_PAINT,
    S_DONE
  } state_t;

  state_t                             state_q, state_d;
  logic [input_pixel_addr_width-1:0]  clr_q, clr_d;
  logic [cnt_width-1:0]               c_q, c_d;
  logic [cnt_width-1:0]               r_q, r_d;
  logic signed [pos_width-1:0]        x0_q, x0_d;
  logic signed [pos_width-1:0]        y0_q, y0_d;
  logic                               paint_data;

  logic signed [ext_width-1:0]        tgt_col;
  logic signed [ext_width-1:0]        tgt_row;
  logic                               in_canvas;
  logic [input_pixel_addr_width-1:0]  paint_addr;

  logic                               draw_ready;
  logic [input_pixel_addr_width-1:0]  pixel_addr;
  logic                               pixel_data;
  logic                               pixel_we;

`ifdef CANVAS_ERASER_EN
  logic erase_q, erase_d;
  assign paint_data = ~erase_q;
`else
  assign paint_data = 1'b1;
`endif

  // State, counters and latched brush origin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      clr_q   <= '0;
      c_q     <= '0;
      r_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
`ifdef CANVAS_ERASER_EN
      erase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      c_q     <= c_d;
      r_q     <= r_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
`ifdef CANVAS_ERASER_EN
      erase_q <= erase_d;
`endif
    end
  end

  // Target pixel of the current brush cell; signed so strokes near the edge clip instead of wrapping
  always_comb begin
    tgt_col    = ext_width'(x0_q) + ext_width'(c_q);
    tgt_row    = ext_width'(y0_q) + ext_width'(r_q);
    in_canvas  = !tgt_col[ext_width-1] && !tgt_row[ext_width-1] &&
                 (tgt_col < side_ext) && (tgt_row < side_ext);
    paint_addr = input_pixel_addr_width'(
                   prod_width'(tgt_row[coord_width-1:0]) * prod_width'(input_matrix_side_length) +
                   prod_width'(tgt_col[coord_width-1:0]));
  end

  // Next state and output decode
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    c_d        = c_q;
    r_d        = r_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
`ifdef CANVAS_ERASER_EN
    erase_d    = erase_q;
`endif
    draw_ready = 1'b0;
    pixel_addr = '0;
    pixel_data = 1'b0;
    pixel_we   = 1'b0;
    done       = 1'b0;
    busy       = (state_q == S_CLEAR) || (state_q == S_PAINT) || (state_q == S_DONE);

    if (en) begin
      unique case (state_q)
        S_RESET: state_d = S_IDLE;
        S_IDLE: begin
          draw_ready = !clear;
          if (clear) begin
            state_d = S_CLEAR;
            clr_d   = '0;
          end else if (bus.draw_valid) begin
            state_d = S_PAINT;
            c_d     = '0;
            r_d     = '0;
            x0_d    = pos_width'(bus.draw_x) - pos_width'(brush_size / 2);
            y0_d    = pos_width'(bus.draw_y) - pos_width'(brush_size / 2);
`ifdef CANVAS_ERASER_EN
            erase_d = bus.draw_erase;
`endif
          end
        end
        S_CLEAR: begin
          pixel_we   = 1'b1;
          pixel_addr = clr_q;
          if (clr_q == last_addr) begin
            state_d = S_DONE;
            clr_d   = '0;
          end else begin
            clr_d = clr_q + input_pixel_addr_width'(1);
          end
        end
        S_PAINT: begin
          // Clipped cells still consume their cycle
          pixel_we   = in_canvas;
          pixel_data = in_canvas & paint_data;
          pixel_addr = in_canvas ? paint_addr : '0;
          if (c_q == brush_last) begin
            c_d = '0;
            if (r_q == brush_last) begin
              r_d     = '0;
              state_d = S_DONE;
            end else begin
              r_d = r_q + cnt_width'(1);
            end
          end else begin
            c_d = c_q + cnt_width'(1);
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  assign bus.draw_ready = draw_ready;
  assign bus.pixel_addr = pixel_addr;
  assign bus.pixel_data = pixel_data;
  assign bus.pixel_we   = pixel_we;

endmodule
